// File: rtl/trng_harvester.sv
// rtl/trng_harvester.sv - ring-oscillator entropy harvester with word packing and RCT health test
// Optional feature macro: TRNG_VN_DEBIAS_EN (von Neumann debiasing of raw sample pairs)
module trng_harvester #(
  parameter int N_CH       = 4,
  parameter int WORD_W     = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int WARMUP_CYC = 16,
  parameter int RCT_LIMIT  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [N_CH-1:0]   i_ch_mask,
  input  logic [N_CH-1:0]   i_ro_bits,
  output logic [N_CH-1:0]   o_ro_en,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_health_fail
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
  localparam int WARM_W = $clog2(WARMUP_CYC + 1);
  localparam int RCT_W  = $clog2(RCT_LIMIT + 1);
  localparam int BCNT_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_COLLECT = 3'd2,
    S_HOLD    = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  state_t              r_state;
  logic [N_CH-1:0]     r_sync1;
  logic [N_CH-1:0]     r_sync2;
  logic [WARM_W-1:0]   r_warm;
  logic [DIV_W-1:0]    r_div;
  logic [RCT_W-1:0]    r_rct_cnt;
  logic                r_rct_prev;
  logic [WORD_W-1:0]   r_shift;
  logic [BCNT_W-1:0]   r_bcnt;

  logic                w_raw;
  logic                w_strobe;
  logic [RCT_W-1:0]    w_rct_next;
  logic                w_rct_trip;
  logic                w_accept;
  logic                w_bit;
  logic                w_word_done;
  logic [WORD_W-1:0]   w_shift_next;

  // Two-flop synchroniser for the asynchronous RO outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_ro_bits;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw    = ^(r_sync2 & i_ch_mask);
  assign w_strobe = (r_state == S_COLLECT) && (r_div == DIV_W'(SAMPLE_DIV - 1));

  // A zero count means the history was just cleared, so the first sample starts a run of one
  assign w_rct_next = ((r_rct_cnt != '0) && (w_raw == r_rct_prev)) ? (r_rct_cnt + 1'b1) : RCT_W'(1);
  assign w_rct_trip = w_strobe && (w_rct_next >= RCT_W'(RCT_LIMIT));

`ifdef TRNG_VN_DEBIAS_EN
  logic r_vn_have;
  logic r_vn_a;

  // Pair phase tracking; the pair is dropped whenever collection is not running
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en || (r_state != S_COLLECT)) begin
      r_vn_have <= 1'b0;
      r_vn_a    <= 1'b0;
    end else if (w_strobe) begin
      r_vn_have <= ~r_vn_have;
      if (!r_vn_have) r_vn_a <= w_raw;
    end
  end

  // Only differing pairs yield a bit, and that bit is the first of the pair
  assign w_accept = w_strobe && r_vn_have && (r_vn_a != w_raw);
  assign w_bit    = r_vn_a;
`else
  assign w_accept = w_strobe;
  assign w_bit    = w_raw;
`endif

  assign w_word_done  = w_accept && (r_bcnt == BCNT_W'(WORD_W - 1));
  assign w_shift_next = {r_shift[WORD_W-2:0], w_bit};

  // Harvester FSM with registered outputs; FAIL is sticky, EN=0 aborts everything else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_health_fail <= 1'b0;
      o_ro_en       <= '0;
      r_warm        <= '0;
      r_div         <= '0;
      r_rct_cnt     <= '0;
      r_rct_prev    <= 1'b0;
      r_shift       <= '0;
      r_bcnt        <= '0;
    end else if (r_state == S_FAIL) begin
      o_ro_en       <= '0;
      o_valid       <= 1'b0;
      o_health_fail <= 1'b1;
    end else if (!i_en) begin
      r_state <= S_IDLE;
      o_valid <= 1'b0;
      o_ro_en <= '0;
      r_warm  <= '0;
      r_div   <= '0;
      r_shift <= '0;
      r_bcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_WARMUP;
          o_ro_en    <= i_ch_mask;
          r_warm     <= '0;
          r_rct_cnt  <= '0;
          r_rct_prev <= 1'b0;
        end
        S_WARMUP: begin
          o_ro_en <= i_ch_mask;
          if (r_warm == WARM_W'(WARMUP_CYC - 1)) begin
            r_state <= S_COLLECT;
            r_div   <= '0;
          end else begin
            r_warm <= r_warm + 1'b1;
          end
        end
        S_COLLECT: begin
          o_ro_en <= i_ch_mask;
          r_div   <= w_strobe ? '0 : (r_div + 1'b1);
          if (w_strobe) begin
            r_rct_cnt  <= w_rct_next;
            r_rct_prev <= w_raw;
          end
          if (w_rct_trip) begin
            r_state       <= S_FAIL;
            o_ro_en       <= '0;
            o_valid       <= 1'b0;
            o_health_fail <= 1'b1;
          end else if (w_word_done) begin
            r_state <= S_HOLD;
            o_data  <= w_shift_next;
            o_valid <= 1'b1;
            r_shift <= '0;
            r_bcnt  <= '0;
          end else if (w_accept) begin
            r_shift <= w_shift_next;
            r_bcnt  <= r_bcnt + 1'b1;
          end
        end
        S_HOLD: begin
          o_ro_en <= i_ch_mask;
          if (i_ready) begin
            r_state <= S_COLLECT;
            o_valid <= 1'b0;
            r_div   <= '0;
            r_shift <= '0;
            r_bcnt  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_valid <= 1'b0;
          o_ro_en <= '0;
        end
      endcase
    end
  end

endmodule
